// File: rtl/valve_servo_bank_if.sv
// valve_servo_bank_if
//   Command channel between the instruction decoder and the valve servo bank.
//   Carries one decoded valve command per ready/valid transfer and the
//   error pulse reported for an out-of-range valve index.
//
//   cmd_valid  decoder -> bank   command present
//   cmd_valve  decoder -> bank   valve index (4 bits)
//   cmd_open   decoder -> bank   1 = open, 0 = close
//   cmd_ready  bank -> decoder   bank can accept a command
//   cmd_err    bank -> decoder   one-cycle pulse on an out-of-range index
//
//   master : the decoder side, slave : the servo bank side.
interface valve_servo_bank_if;
  logic       cmd_valid;
  logic [3:0] cmd_valve;
  logic       cmd_open;
  logic       cmd_ready;
  logic       cmd_err;

  modport master (
    output cmd_valid,
    output cmd_valve,
    output cmd_open,
    input  cmd_ready,
    input  cmd_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_valve,
    input  cmd_open,
    output cmd_ready,
    output cmd_err
  );
endinterface

// File: rtl/valve_servo_bank.sv
// valve_servo_bank
//   Multi-channel hobby-servo PWM stage. Accepts valve open/close commands over
//   a ready/valid channel and drives one PWM line per valve. New pulse widths
//   only take effect on a frame boundary, so every pulse on a pin is complete.
//
//   Optional feature macro: SERVO_SLEW_EN
//     When defined, widths walk toward their targets by at most SLEW_STEP per
//     frame and the bank stays busy until every channel has arrived.
//
//   Ports
//     clk          system clock
//     rst          asynchronous active-low reset
//     cmd          slave side of valve_servo_bank_if (command channel)
//     pwm          servo PWM lines, one per valve (registered)
//     valve_state  commanded position per valve, 1 = open (registered)
//     settled      idle with every width at its target (registered)
module valve_servo_bank #(
  parameter int NUM_VALVES = 4,
  parameter int PERIOD_CYC = 2000000,
  parameter int OPEN_CYC   = 200000,
  parameter int CLOSED_CYC = 100000
`ifdef SERVO_SLEW_EN
  , parameter int SLEW_STEP = 10000
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  valve_servo_bank_if.slave     cmd,
  output logic [NUM_VALVES-1:0] pwm,
  output logic [NUM_VALVES-1:0] valve_state,
  output logic                  settled
);

  localparam int CW = (PERIOD_CYC > 1) ? $clog2(PERIOD_CYC) : 1;
  localparam logic [CW-1:0] LAST_W   = CW'(PERIOD_CYC - 1);
  localparam logic [CW-1:0] OPEN_W   = CW'(OPEN_CYC);
  localparam logic [CW-1:0] CLOSED_W = CW'(CLOSED_CYC);
  localparam logic [CW-1:0] ONE_W    = CW'(1);
  localparam logic [4:0]    NUM_W    = 5'(NUM_VALVES);

`ifdef SERVO_SLEW_EN
  localparam logic [CW-1:0] STEP_W = CW'(SLEW_STEP);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PENDING = 2'd1, ST_SLEWING = 2'd2} state_t;

  // One frame's move from cur toward tgt, clamped so it never passes tgt.
  function automatic logic [CW-1:0] slew_toward(input logic [CW-1:0] cur,
                                                input logic [CW-1:0] tgt);
    logic [CW-1:0] res;
    if (cur < tgt) begin
      if ((tgt - cur) > STEP_W) res = cur + STEP_W;
      else                      res = tgt;
    end else if (cur > tgt) begin
      if ((cur - tgt) > STEP_W) res = cur - STEP_W;
      else                      res = tgt;
    end else begin
      res = cur;
    end
    return res;
  endfunction
`else
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PENDING = 2'd1} state_t;
`endif

  state_t                state_r, state_nx_s;
  logic [CW-1:0]         frame_cnt_r;
  logic [CW-1:0]         target_r    [NUM_VALVES];
  logic [CW-1:0]         width_r     [NUM_VALVES];
  logic [CW-1:0]         target_nx_s [NUM_VALVES];
  logic [CW-1:0]         width_nx_s  [NUM_VALVES];
  logic [NUM_VALVES-1:0] vstate_r, vstate_nx_s;
  logic [NUM_VALVES-1:0] pwm_r;
  logic                  cmd_ready_r, cmd_err_r, cmd_err_nx_s;
  logic                  settled_r, settled_nx_s;
  logic                  boundary_s, valid_idx_s;

  // The wrap cycle of the frame counter is the only point widths may change.
  assign boundary_s  = (frame_cnt_r == LAST_W);
  assign valid_idx_s = ({1'b0, cmd.cmd_valve} < NUM_W);

  // Next-state, next-target and next-width logic for the command FSM.
  always_comb begin
    state_nx_s   = state_r;
    target_nx_s  = target_r;
    width_nx_s   = width_r;
    vstate_nx_s  = vstate_r;
    cmd_err_nx_s = 1'b0;
    settled_nx_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd.cmd_valid && valid_idx_s) begin
          for (int i = 0; i < NUM_VALVES; i++) begin
            if (cmd.cmd_valve == 4'(i)) begin
              target_nx_s[i] = cmd.cmd_open ? OPEN_W : CLOSED_W;
              vstate_nx_s[i] = cmd.cmd_open;
            end else begin
              target_nx_s[i] = target_r[i];
              vstate_nx_s[i] = vstate_r[i];
            end
          end
          state_nx_s = ST_PENDING;
        end else if (cmd.cmd_valid) begin
          cmd_err_nx_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
`ifdef SERVO_SLEW_EN
      ST_PENDING, ST_SLEWING: begin
        if (boundary_s) begin
          state_nx_s = ST_IDLE;
          for (int i = 0; i < NUM_VALVES; i++) begin
            width_nx_s[i] = slew_toward(width_r[i], target_r[i]);
            if (width_nx_s[i] != target_r[i]) state_nx_s = ST_SLEWING;
            else                              state_nx_s = state_nx_s;
          end
        end else begin
          state_nx_s = state_r;
        end
      end
`else
      ST_PENDING: begin
        if (boundary_s) begin
          width_nx_s = target_r;
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_PENDING;
        end
      end
`endif
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
    // settled is computed from next values so it moves together with cmd_ready.
    settled_nx_s = (state_nx_s == ST_IDLE);
    for (int i = 0; i < NUM_VALVES; i++) begin
      if (width_nx_s[i] != target_nx_s[i]) settled_nx_s = 1'b0;
      else                                 settled_nx_s = settled_nx_s;
    end
  end

  // Frame counter, PWM pins, channel widths/targets and handshake registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      frame_cnt_r <= {CW{1'b0}};
      for (int i = 0; i < NUM_VALVES; i++) begin
        target_r[i] <= CLOSED_W;
        width_r[i]  <= CLOSED_W;
      end
      vstate_r    <= {NUM_VALVES{1'b0}};
      pwm_r       <= {NUM_VALVES{1'b0}};
      cmd_ready_r <= 1'b1;
      cmd_err_r   <= 1'b0;
      settled_r   <= 1'b1;
    end else begin
      state_r     <= state_nx_s;
      frame_cnt_r <= boundary_s ? {CW{1'b0}} : (frame_cnt_r + ONE_W);
      for (int i = 0; i < NUM_VALVES; i++) begin
        pwm_r[i]    <= (frame_cnt_r < width_r[i]);
        target_r[i] <= target_nx_s[i];
        width_r[i]  <= width_nx_s[i];
      end
      vstate_r    <= vstate_nx_s;
      cmd_ready_r <= (state_nx_s == ST_IDLE);
      cmd_err_r   <= cmd_err_nx_s;
      settled_r   <= settled_nx_s;
    end
  end

  assign cmd.cmd_ready = cmd_ready_r;
  assign cmd.cmd_err   = cmd_err_r;
  assign pwm           = pwm_r;
  assign valve_state   = vstate_r;
  assign settled       = settled_r;

endmodule

// File: tb/tb_valve_servo_bank.sv
// tb_valve_servo_bank
//   Directed bench for valve_servo_bank with a 100-cycle frame, 20/10-cycle
//   open/closed pulses and a 4-cycle slew step. Expected values are worked
//   out by hand for each scenario. fc tracks which frame position the DUT
//   counter holds; it is sampled on the falling edge.
module tb_valve_servo_bank;

  logic       clk;
  logic       rst;
  logic [3:0] pwm;
  logic [3:0] valve_state;
  logic       settled;

  valve_servo_bank_if cmd_bus ();

  valve_servo_bank #(
    .NUM_VALVES (4),
    .PERIOD_CYC (100),
    .OPEN_CYC   (20),
    .CLOSED_CYC (10)
`ifdef SERVO_SLEW_EN
    , .SLEW_STEP (4)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd_bus),
    .pwm         (pwm),
    .valve_state (valve_state),
    .settled     (settled)
  );

  int checks_cnt = 0;
  int errors_cnt = 0;
  int fc;
  int hi_cnt [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame position the DUT counter will present on the next rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) fc <= 0;
    else      fc <= (fc == 99) ? 0 : fc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      errors_cnt++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance at least one falling edge, stopping where fc == n.
  task automatic wait_fc(input int n);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (fc != n && guard < 300);
    check_eq("wait_fc_bound", fc, n);
  endtask

  // Count pwm high cycles over one whole frame (counter values 0..99).
  task automatic check_frame(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    for (int v = 0; v < 4; v++) hi_cnt[v] = 0;
    wait_fc(1);
    for (int k = 0; k < 100; k++) begin
      if (k > 0) @(negedge clk);
      for (int v = 0; v < 4; v++) hi_cnt[v] += int'(pwm[v]);
    end
    for (int v = 0; v < 4; v++) check_eq($sformatf("%s_v%0d", tag, v), hi_cnt[v], exp_v[v]);
  endtask

  task automatic drive(input logic valid, input logic [3:0] valve, input logic open_cmd);
    cmd_bus.cmd_valid = valid;
    cmd_bus.cmd_valve = valve;
    cmd_bus.cmd_open  = open_cmd;
  endtask

  initial begin
    int n;
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_pwm",     pwm, 4'b0000);
    check_eq("rst_ready",   cmd_bus.cmd_ready, 1'b1);
    check_eq("rst_settled", settled, 1'b1);
    check_eq("rst_vstate",  valve_state, 4'b0000);
    check_eq("rst_err",     cmd_bus.cmd_err, 1'b0);
    rst = 1'b1;
    check_frame("rst_frame", 10, 10, 10, 10);

`ifdef SERVO_SLEW_EN
    // Open valve 0: widths 14, 18, 20 on successive frames.
    wait_fc(40);
    drive(1'b1, 4'd0, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0);
    check_eq("slew_ready_lo", cmd_bus.cmd_ready, 1'b0);
    check_frame("slew_f14", 14, 10, 10, 10);
    check_eq("slew_settled_f18", settled, 1'b0);
    check_eq("slew_ready_f18",   cmd_bus.cmd_ready, 1'b0);
    check_frame("slew_f18", 18, 10, 10, 10);
    check_eq("slew_settled_f20", settled, 1'b1);
    check_eq("slew_ready_f20",   cmd_bus.cmd_ready, 1'b1);
    check_frame("slew_f20", 20, 10, 10, 10);
`else
    // Open valve 2 mid-frame.
    wait_fc(40);
    drive(1'b1, 4'd2, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0);
    check_eq("open2_ready_lo", cmd_bus.cmd_ready, 1'b0);
    check_eq("open2_vstate",   valve_state, 4'b0100);
    check_eq("open2_settled",  settled, 1'b0);
    wait_fc(99);
    check_eq("open2_ready_fc99", cmd_bus.cmd_ready, 1'b0);
    check_frame("open2_frame", 10, 10, 20, 10);
    check_eq("open2_ready_hi",  cmd_bus.cmd_ready, 1'b1);
    check_eq("open2_settled_hi", settled, 1'b1);

    // Command accepted on the boundary cycle waits a whole extra frame.
    wait_fc(99);
    drive(1'b1, 4'd1, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0);
    check_eq("bnd_ready_lo", cmd_bus.cmd_ready, 1'b0);
    check_frame("bnd_frame1", 10, 10, 20, 10);
    check_frame("bnd_frame2", 10, 20, 20, 10);
    check_eq("bnd_vstate", valve_state, 4'b0110);

    // Out-of-range index.
    wait_fc(30);
    drive(1'b1, 4'd5, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0);
    check_eq("bad_err_hi",  cmd_bus.cmd_err, 1'b1);
    check_eq("bad_ready",   cmd_bus.cmd_ready, 1'b1);
    check_eq("bad_vstate",  valve_state, 4'b0110);
    @(negedge clk);
    check_eq("bad_err_lo",  cmd_bus.cmd_err, 1'b0);
    check_frame("bad_frame", 10, 20, 20, 10);

    // Valid held while busy with a different valve is taken once ready returns.
    wait_fc(10);
    drive(1'b1, 4'd3, 1'b1);
    @(negedge clk);
    check_eq("hold_ready_lo", cmd_bus.cmd_ready, 1'b0);
    drive(1'b1, 4'd0, 1'b1);
    n = 0;
    while (cmd_bus.cmd_ready !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check_eq("hold_ready_fc", fc, 0);
    check_eq("hold_vstate_pre", valve_state, 4'b1110);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0);
    check_eq("hold_ready_lo2", cmd_bus.cmd_ready, 1'b0);
    check_eq("hold_vstate",    valve_state, 4'b1111);
    check_frame("hold_frame", 20, 20, 20, 20);
    check_eq("hold_ready_hi",  cmd_bus.cmd_ready, 1'b1);
    check_eq("hold_vstate_end", valve_state, 4'b1111);
`endif

    // Reset pulsed in the middle of a transaction, while pwm is high.
    wait_fc(40);
    drive(1'b1, 4'd1, 1'b1);
    @(negedge clk);
    drive(1'b0, 4'd0, 1'b0);
    wait_fc(5);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_pwm",     pwm, 4'b0000);
    check_eq("mid_rst_vstate",  valve_state, 4'b0000);
    check_eq("mid_rst_ready",   cmd_bus.cmd_ready, 1'b1);
    check_eq("mid_rst_settled", settled, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    check_frame("mid_rst_frame", 10, 10, 10, 10);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
